// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
package cache_pkg;

    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {StIdle, StLookup, StWriteback, StFill} state_t;

    function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b,
                                              input logic en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// CPU-side line bus and physical-memory bus of the cache, bundled as one interface.
interface cache_assoc_if #(
    parameter int unsigned LINE_BITS = 256
);
    logic                   mem_read;
    logic                   mem_write;
    logic [31:0]            mem_address;
    logic [LINE_BITS-1:0]   mem_wdata;
    logic [LINE_BITS/8-1:0] mem_byte_enable;
    logic [LINE_BITS-1:0]   mem_rdata;
    logic                   mem_resp;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [31:0]            pmem_address;
    logic [LINE_BITS-1:0]   pmem_wdata;
    logic [LINE_BITS-1:0]   pmem_rdata;
    logic                   pmem_resp;

    // Environment side: CPU requester plus physical memory.
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    // Cache side.
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_assoc_plru_tree.sv
// Combinational tree-PLRU: bit update on a hit and victim selection. Each node bit
// points at the subtree holding the victim (0 = lower half).
module plru_tree #(
    parameter int unsigned WAYS = 4,
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] bits,
    input  logic [WAY_W-1:0]  hit_way,
    output logic [PLRU_W-1:0] bits_upd,
    output logic [WAY_W-1:0]  victim
);
    localparam int unsigned LEVELS = $clog2(WAYS);
    localparam int unsigned NODE_W = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;

    always_comb begin
        int unsigned node;
        logic dir;
        bits_upd = bits;
        node = 0;
        dir = 1'b0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            dir = 1'(hit_way >> (LEVELS - 1 - l));
            bits_upd[NODE_W'(node)] = ~dir;
            node = 2 * node + 1 + 32'(dir);
        end
    end

    always_comb begin
        int unsigned node;
        logic dir;
        victim = '0;
        node = 0;
        dir = 1'b0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            dir = bits[NODE_W'(node)];
            victim = (victim << 1) | WAY_W'(dir);
            node = 2 * node + 1 + 32'(dir);
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-back / write-allocate cache with tree-PLRU replacement.
// Flop-array storage, single FSM handling lookup, victim writeback and line fill.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8,
    parameter int unsigned LINE_BITS = 256
) (
    input logic         clk,
    input logic         rst_n,
    cache_assoc_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 32 - OFFSET_W - IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned BYTES  = LINE_BITS / 8;

    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [SETS-1:0]      valid_q [WAYS];
    logic [SETS-1:0]      dirty_q [WAYS];
    logic [PLRU_W-1:0]    plru_q  [SETS];

    state_t                    state_q, state_d;
    logic [31-OFFSET_W:0]      line_q;
    logic [LINE_BITS-1:0]      wdata_q;
    logic [BYTES-1:0]          be_q;
    logic                      write_q;
    logic [WAY_W-1:0]          victim_q;
    logic                      installed_q;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim_way;
    logic [WAY_W-1:0]     plru_victim;
    logic [PLRU_W-1:0]    plru_upd;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] merged;
    logic                 fill_now;

    assign idx      = line_q[IDX_W-1:0];
    assign tag      = line_q[IDX_W +: TAG_W];
    assign hit_line = data_q[hit_way][idx];
    assign fill_now = (state_q == StFill) && bus.pmem_resp && !installed_q;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits     (plru_q[idx]),
        .hit_way  (hit_way),
        .bits_upd (plru_upd),
        .victim   (plru_victim)
    );

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Downward scan leaves the lowest-index invalid way, if any.
    always_comb begin
        victim_way = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) victim_way = WAY_W'(w);
        end
    end

    always_comb begin
        merged = '0;
        for (int b = 0; b < BYTES; b++) begin
            merged[8*b +: 8] = merge_byte(hit_line[8*b +: 8], wdata_q[8*b +: 8], be_q[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FILL lingers one cycle after install so the strobe drops before LOOKUP re-runs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (bus.mem_read || bus.mem_write) state_d = StLookup;
            StLookup: begin
                if (hit) state_d = StIdle;
                else if (valid_q[victim_way][idx] && dirty_q[victim_way][idx])
                    state_d = StWriteback;
                else state_d = StFill;
            end
            StWriteback: if (bus.pmem_resp) state_d = StFill;
            StFill:      if (installed_q) state_d = StLookup;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        unique case (state_q)
            StLookup: begin
                if (hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = hit_line;
                end
            end
            StWriteback: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[victim_q][idx], idx, {OFFSET_W{1'b0}}};
                bus.pmem_wdata   = data_q[victim_q][idx];
            end
            StFill: begin
                bus.pmem_read    = !installed_q;
                bus.pmem_address = {tag, idx, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
            victim_q    <= '0;
            installed_q <= 1'b0;
        end else begin
            if (state_q == StIdle && (bus.mem_read || bus.mem_write)) begin
                line_q  <= bus.mem_address[31:OFFSET_W];
                wdata_q <= bus.mem_wdata;
                be_q    <= bus.mem_byte_enable;
                write_q <= bus.mem_write;
            end
            if (state_q == StLookup && !hit) victim_q <= victim_way;
            installed_q <= fill_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            if (state_q == StLookup && hit) begin
                plru_q[idx] <= plru_upd;
                if (write_q) dirty_q[hit_way][idx] <= 1'b1;
            end
            if (state_q == StWriteback && bus.pmem_resp) dirty_q[victim_q][idx] <= 1'b0;
            if (fill_now) begin
                valid_q[victim_q][idx] <= 1'b1;
                dirty_q[victim_q][idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_now) begin
            data_q[victim_q][idx] <= bus.pmem_rdata;
            tag_q[victim_q][idx]  <= tag;
        end else if (state_q == StLookup && hit && write_q) begin
            data_q[hit_way][idx] <= merged;
        end
    end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised set-associative, write-back, write-allocate cache: the successor to the direct-mapped 8-set cache datapath. It merges datapath and control FSM into one block, with configurable ways and sets and tree-PLRU replacement. It sits between the CPU-side 256-bit line interface (behind the line adapter) and physical memory/arbiter. It presents the same mem_*/pmem_* signal set as the existing cache.

## Interface
- WAYS, 4, associativity; power of 2, 1..8
- SETS, 8, sets per way; power of 2, 2..64
- LINE_BITS, 256, line width; byte enables are LINE_BITS/8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  byte address; offset [4:0], index [4+log2 SETS:5], tag above
- mem_wdata  in  LINE_BITS  write line
- mem_byte_enable  in  LINE_BITS/8  byte mask for writes
- mem_rdata  out  LINE_BITS  hit line, valid while mem_resp=1
- mem_resp  out  1  single-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line-aligned address (low 5 bits 0)
- pmem_wdata  out  LINE_BITS  victim line
- pmem_rdata  in  LINE_BITS  fill line, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- Storage per way: data[SETS], tag[SETS], valid[SETS], dirty[SETS]; per set: PLRU bits (WAYS-1). Flop arrays, combinational read.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE: mem_read|mem_write -> capture address/wdata/mask, go to LOOKUP.
- LOOKUP: hit = valid & tag match in any way (at most one).
  - Read hit: mem_rdata = line, mem_resp=1.
  - Write hit: merge bytes where mask=1, set dirty, mem_resp=1.
  - Either hit: update PLRU to point away from the hit way, go to IDLE.
  - Miss: pick victim = lowest-index invalid way, else the PLRU way. Victim valid&dirty -> WRITEBACK, else FILL.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line. On pmem_resp: clear dirty, go to FILL.
- FILL: pmem_read=1, pmem_address={tag, index, 5'b0}. On pmem_resp: write line into victim, tag, valid=1, dirty=0, go to LOOKUP (which then hits).
- mem_read and mem_write together are illegal; the block treats the request as a write.
- PLRU is not updated on fill, only on the LOOKUP hit that follows.
- WAYS=1: PLRU is absent and the victim is always way 0.

## Timing
- Reset (async assert, sync-free deassert) does the following:
  - FSM goes to IDLE.
  - Every valid, dirty and PLRU bit clears.
  - mem_resp, pmem_read and pmem_write are 0; mem_rdata, pmem_address and pmem_wdata are 0.
- Hit latency: request in cycle N (IDLE), mem_resp in cycle N+1.
- Clean miss: mem_resp 2 cycles after pmem_resp of the fill.
- Dirty miss: writeback handshake, then fill, then LOOKUP.
- pmem_read and pmem_write are never high together. They deassert in the cycle after pmem_resp.
- pmem_resp outside WRITEBACK/FILL is ignored.
- CPU request inputs are sampled only in IDLE; changes mid-miss have no effect.
- Reset mid-miss drops the pmem strobe immediately. The in-flight memory response is ignored and the line is not installed.

## Structure
- Package cache_pkg holds:
  - state_t enum.
  - Localparams OFFSET_W=5, IDX_W=$clog2(SETS), TAG_W=32-OFFSET_W-IDX_W, computed in-module from parameters.
  - Function for the byte-mask merge.
- Sub-module plru_tree #(WAYS) has two functions:
  - Takes the per-set PLRU bits and a hit way; returns the updated bits.
  - Takes the bits alone; returns the victim way.
  - It is combinational; the cache owns the storage.

## Test plan
- Cold read 0x0000_0100 (WAYS=4, SETS=8): FILL with pmem_address 0x100, pmem_rdata=A. mem_resp 2 cycles after pmem_resp, mem_rdata=A, pmem_write never asserted.
- Read again 0x100: mem_resp in the cycle after the request, no pmem activity.
- Write 0x100 with mask 0x0000_000F and wdata=B, then read: low 4 bytes from B, rest from A. Dirty is set.
- Fill five tags into set 0 (0x000, 0x100, 0x200, 0x300, 0x400), with hits on 0x000 and 0x200 before the fifth: the victim is the PLRU way. If that way is dirty, the writeback goes to its address before the fill of 0x400.
- Dirty victim: pmem_write precedes pmem_read, both are never high together, and each drops the cycle after its pmem_resp.
- Assert rst_n=0 during FILL: pmem_read drops asynchronously. After release, a read to the same address misses again.
